// File: rtl/gate_stim_checker.sv
// Self-test sequencer for a 2-input gate block: sweeps {a,b} through 00..11,
// checks the seven returned gate outputs and reports pass, error count and first failure.
module gate_stim_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOOPS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic [6:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_y
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] LOOP_LAST = 4'(LOOPS - 1);

    state_t     state, state_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic [1:0] vec_idx, vec_nxt;
    logic [3:0] loop_cnt, loop_nxt;
    logic       err_seen, err_seen_nxt;
    logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [3:0] err_cnt_nxt;
    logic [1:0] fail_vec_nxt;
    logic [6:0] fail_y_nxt;

    logic [6:0] exp_y;
    logic       mismatch, hold_end, last_vec;

    // Reference model of the gate block for the vector currently driven.
    assign exp_y    = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    assign mismatch = (y != exp_y);
    assign hold_end = (hold_cnt == HOLD_LAST);
    assign last_vec = (vec_idx == 2'd3) && (loop_cnt == LOOP_LAST);

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        vec_nxt      = vec_idx;
        loop_nxt     = loop_cnt;
        err_seen_nxt = err_seen;
        a_nxt        = a;
        b_nxt        = b;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        pass_nxt     = pass;
        err_cnt_nxt  = err_cnt;
        fail_vec_nxt = fail_vec;
        fail_y_nxt   = fail_y;

        case (state)
            IDLE: begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
                if (start && !abort) begin
                    state_nxt    = RUN;
                    hold_nxt     = '0;
                    vec_nxt      = '0;
                    loop_nxt     = '0;
                    err_seen_nxt = 1'b0;
                    busy_nxt     = 1'b1;
                    pass_nxt     = 1'b0;
                    err_cnt_nxt  = '0;
                    fail_vec_nxt = '0;
                    fail_y_nxt   = '0;
                end
            end

            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    busy_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end else if (hold_end) begin
                    if (mismatch) begin
                        err_seen_nxt = 1'b1;
                        if (err_cnt != 4'hF)
                            err_cnt_nxt = err_cnt + 4'd1;
                        if (!err_seen) begin
                            fail_vec_nxt = {a, b};
                            fail_y_nxt   = y;
                        end
                    end
                    if (last_vec) begin
                        // Final compare folds straight into pass on the DONE edge.
                        state_nxt = DONE;
                        a_nxt     = 1'b0;
                        b_nxt     = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = !(err_seen || mismatch);
                    end else begin
                        hold_nxt       = '0;
                        vec_nxt        = vec_idx + 2'd1;
                        {a_nxt, b_nxt} = vec_idx + 2'd1;
                        if (vec_idx == 2'd3)
                            loop_nxt = loop_cnt + 4'd1;
                    end
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
                a_nxt     = 1'b0;
                b_nxt     = 1'b0;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            vec_idx  <= '0;
            loop_cnt <= '0;
            err_seen <= 1'b0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
            fail_y   <= '0;
        end else begin
            hold_cnt <= hold_nxt;
            vec_idx  <= vec_nxt;
            loop_cnt <= loop_nxt;
            err_seen <= err_seen_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            pass     <= pass_nxt;
            err_cnt  <= err_cnt_nxt;
            fail_vec <= fail_vec_nxt;
            fail_y   <= fail_y_nxt;
        end
    end

endmodule
